// File: rtl/mcu_tx_arbiter.sv
// Round-robin arbiter sharing one MCU serial transmit channel among three packet requesters.
// state | meaning: IDLE pick requester; ISSUE accept one byte; GUARD ignore late busy; WAIT pace on busy/timeout
module mcu_tx_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ready,
  output logic [7:0]  tx_data_4x,
  output logic        tx_new_data_4x,
  input  logic        tx_busy_4x,
  output logic        pkt_active,
  output logic [1:0]  grant,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;

  localparam logic [3:0]  GUARD_LOAD   = 4'(GUARD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_grant;
  logic [1:0]  r_last_grant;
  logic        r_active;
  logic        r_last;
  logic [7:0]  r_data;
  logic        r_strobe;
  logic        r_err;
  logic [3:0]  r_gcnt;
  logic [15:0] r_tcnt;

  logic [1:0]  w_pick;
  logic        w_any;
  logic        w_sel_valid;
  logic [7:0]  w_sel_data;
  logic        w_sel_last;
  logic [2:0]  w_ready;

  // Scan starts just after the previous owner so every requester gets a turn.
  always_comb begin
    w_pick = 2'd0;
    w_any  = |req_valid;
    case (r_last_grant)
      2'd0:    w_pick = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
      2'd1:    w_pick = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
      default: w_pick = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = 8'h00;
    w_sel_last  = 1'b0;
    w_ready     = 3'b000;
    case (r_grant)
      2'd0: begin
        w_sel_valid = req_valid[0];
        w_sel_data  = req_data[7:0];
        w_sel_last  = req_last[0];
        w_ready     = 3'b001;
      end
      2'd1: begin
        w_sel_valid = req_valid[1];
        w_sel_data  = req_data[15:8];
        w_sel_last  = req_last[1];
        w_ready     = 3'b010;
      end
      2'd2: begin
        w_sel_valid = req_valid[2];
        w_sel_data  = req_data[23:16];
        w_sel_last  = req_last[2];
        w_ready     = 3'b100;
      end
      default: ;
    endcase
    if (r_state != S_ISSUE) w_ready = 3'b000;
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 2'd0;
      r_last_grant <= 2'd2;
      r_active     <= 1'b0;
      r_last       <= 1'b0;
      r_data       <= 8'h00;
      r_strobe     <= 1'b0;
      r_err        <= 1'b0;
      r_gcnt       <= 4'd0;
      r_tcnt       <= 16'd0;
    end else begin
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_pick;
            r_active <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_sel_valid) begin
            r_data   <= w_sel_data;
            r_last   <= w_sel_last;
            r_strobe <= 1'b1;
            r_gcnt   <= GUARD_LOAD;
            r_state  <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (r_gcnt == 4'd0) begin
            r_tcnt  <= 16'd0;
            r_state <= S_WAIT;
          end else begin
            r_gcnt <= r_gcnt - 4'd1;
          end
        end
        S_WAIT: begin
          if (!tx_busy_4x) begin
            if (r_last) begin
              r_last_grant <= r_grant;
              r_active     <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (r_tcnt == TIMEOUT_LAST) begin
            // Abort the packet; any remaining bytes compete again as a new packet.
            r_err        <= 1'b1;
            r_last_grant <= r_grant;
            r_active     <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = w_ready;
  assign tx_data_4x     = r_data;
  assign tx_new_data_4x = r_strobe;
  assign pkt_active     = r_active;
  assign grant          = r_grant;
  assign err_timeout    = r_err;

endmodule
